// File: rtl/ncl_mult_seq_if.sv
// Dual-rail operand/product bundle with the four-phase Ki/Ko handshake for ncl_mult_seq.
// The producer/consumer side uses the master modport, the multiplier the slave modport.
interface ncl_mult_seq_if #(
  parameter int W = 3
);
  logic [W-1:0]   a_rail1;
  logic [W-1:0]   a_rail0;
  logic [W-1:0]   b_rail1;
  logic [W-1:0]   b_rail0;
  logic           ki;
  logic           ko;
  logic [2*W-1:0] p_rail1;
  logic [2*W-1:0] p_rail0;
  logic           busy;
  logic           err;

  modport master (
    output a_rail1, a_rail0, b_rail1, b_rail0, ki,
    input  ko, p_rail1, p_rail0, busy, err
  );

  modport slave (
    input  a_rail1, a_rail0, b_rail1, b_rail0, ki,
    output ko, p_rail1, p_rail0, busy, err
  );
endinterface

// File: rtl/ncl_mult_seq.sv
// Clocked W x W dual-rail NCL multiplier: synchronised four-phase handshake, shift-add core.
// Optional macro NCL_MULT_ILLEGAL_CHK_EN enables sticky detection of illegal 11 rail pairs.
module ncl_mult_seq #(
  parameter int W = 3
) (
  input logic           clk,
  input logic           rst_n,
  ncl_mult_seq_if.slave bus
);
  localparam int PW = 2 * W;
  localparam int SW = 4 * W + 1;
  localparam int CW = $clog2(W);

  typedef enum logic [2:0] {
    WAIT_DATA = 3'd0,
    MUL       = 3'd1,
    WAIT_KI   = 3'd2,
    HOLD      = 3'd3,
    WAIT_NULL = 3'd4
  } state_t;

  function automatic logic all_data(input logic [PW-1:0] r1, input logic [PW-1:0] r0);
    return &(r1 | r0);
  endfunction

  function automatic logic all_null(input logic [PW-1:0] r1, input logic [PW-1:0] r0);
    return ~|(r1 | r0);
  endfunction

  logic [SW-1:0] sync1_q;
  logic [SW-1:0] sync2_q;
  logic [1:0]    rst_sync_q;
  logic          run_s;

  logic [W-1:0]  a0_s;
  logic [W-1:0]  a1_s;
  logic [W-1:0]  b0_s;
  logic [W-1:0]  b1_s;
  logic          ki_s;
  logic [PW-1:0] r1_s;
  logic [PW-1:0] r0_s;
  logic          data_s;
  logic          null_s;
  logic          capture_s;
  logic [PW-1:0] addend_s;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ko_q, ko_d;
  logic          busy_q, busy_d;
  logic [PW-1:0] p1_q, p1_d;
  logic [PW-1:0] p0_q, p0_d;

  // Two-flop synchronisers for every input rail and ki, plus reset-release synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= {SW{1'b0}};
      sync2_q    <= {SW{1'b0}};
      rst_sync_q <= 2'b00;
    end else begin
      sync1_q    <= {bus.ki, bus.b_rail1, bus.b_rail0, bus.a_rail1, bus.a_rail0};
      sync2_q    <= sync1_q;
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign run_s  = rst_sync_q[1];
  assign a0_s   = sync2_q[W-1:0];
  assign a1_s   = sync2_q[2*W-1:W];
  assign b0_s   = sync2_q[3*W-1:2*W];
  assign b1_s   = sync2_q[4*W-1:3*W];
  assign ki_s   = sync2_q[4*W];
  assign r1_s   = {b1_s, a1_s};
  assign r0_s   = {b0_s, a0_s};
  assign data_s = all_data(r1_s, r0_s);
  assign null_s = all_null(r1_s, r0_s);

`ifdef NCL_MULT_ILLEGAL_CHK_EN
  logic illegal_s;
  logic err_q, err_d;
  logic need_null_q, need_null_d;

  assign illegal_s = |(r1_s & r0_s);
  // An operand set that carried an 11 pair must fully return to NULL before a capture
  assign capture_s = run_s & data_s & ~illegal_s & ~need_null_q;

  // Sticky illegal-code flag and the pending NULL requirement it creates
  always_comb begin
    err_d       = err_q;
    need_null_d = need_null_q;
    if ((state_q == WAIT_DATA) && run_s && illegal_s) begin
      err_d       = 1'b1;
      need_null_d = 1'b1;
    end else if (null_s) begin
      need_null_d = 1'b0;
    end else begin
      need_null_d = need_null_q;
    end
  end

  // Illegal-code state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q       <= 1'b0;
      need_null_q <= 1'b0;
    end else begin
      err_q       <= err_d;
      need_null_q <= need_null_d;
    end
  end

  assign bus.err = err_q;
`else
  assign capture_s = run_s & data_s;
  assign bus.err   = 1'b0;
`endif

  assign addend_s = {{W{1'b0}}, a_q} << cnt_q;

  // Next-state and registered-output logic for the handshake and shift-add sequence
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ko_d    = ko_q;
    busy_d  = busy_q;
    p1_d    = p1_q;
    p0_d    = p0_q;
    case (state_q)
      WAIT_DATA: begin
        ko_d   = 1'b1;
        busy_d = 1'b0;
        if (capture_s) begin
          a_d     = a1_s;
          b_d     = b1_s;
          acc_d   = {PW{1'b0}};
          cnt_d   = {CW{1'b0}};
          ko_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = MUL;
        end else begin
          state_d = WAIT_DATA;
        end
      end
      MUL: begin
        if (b_q[cnt_q]) begin
          acc_d = acc_q + addend_s;
        end else begin
          acc_d = acc_q;
        end
        if (cnt_q == CW'(W - 1)) begin
          cnt_d   = {CW{1'b0}};
          state_d = WAIT_KI;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = MUL;
        end
      end
      WAIT_KI: begin
        // Both rails switch on the same edge, so the output goes NULL to DATA with no mixed code
        if (ki_s) begin
          p1_d    = acc_q;
          p0_d    = ~acc_q;
          state_d = HOLD;
        end else begin
          state_d = WAIT_KI;
        end
      end
      HOLD: begin
        if (!ki_s && null_s) begin
          p1_d    = {PW{1'b0}};
          p0_d    = {PW{1'b0}};
          state_d = WAIT_NULL;
        end else begin
          state_d = HOLD;
        end
      end
      WAIT_NULL: begin
        ko_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = WAIT_DATA;
      end
      default: begin
        ko_d    = 1'b1;
        busy_d  = 1'b0;
        p1_d    = {PW{1'b0}};
        p0_d    = {PW{1'b0}};
        state_d = WAIT_DATA;
      end
    endcase
  end

  // State, datapath and output registers; reset forces NULL outputs and ko high at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_DATA;
      a_q     <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      acc_q   <= {PW{1'b0}};
      cnt_q   <= {CW{1'b0}};
      ko_q    <= 1'b1;
      busy_q  <= 1'b0;
      p1_q    <= {PW{1'b0}};
      p0_q    <= {PW{1'b0}};
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ko_q    <= ko_d;
      busy_q  <= busy_d;
      p1_q    <= p1_d;
      p0_q    <= p0_d;
    end
  end

  assign bus.ko      = ko_q;
  assign bus.busy    = busy_q;
  assign bus.p_rail1 = p1_q;
  assign bus.p_rail0 = p0_q;
endmodule

// File: doc/ncl_mult_seq.md
# ncl_mult_seq

Parametrised, clocked successor of the 3×3 NCL multiplier. It accepts two W-bit dual-rail operands under a four-phase return-to-NULL handshake (Ki/Ko), synchronises them into one clock domain, and computes the unsigned 2W-bit product by iterative shift-add. It drives the product back out as registered dual-rail data. It sits between asynchronous NCL pipeline stages and clocked logic, and serves as a drop-in wide multiplier stage.

## Interface
- W, 3: operand width in bits, ≥2; product width is 2W.
- clk  input  1  sole clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- a_rail1 / a_rail0  input  W each  operand A, dual-rail per bit (10=1, 01=0, 00=NULL).
- b_rail1 / b_rail0  input  W each  operand B, same encoding.
- ki  input  1  downstream request: 1 = request DATA, 0 = request NULL.
- ko  output  1  upstream request: 1 = ready for DATA, 0 = ready for NULL.
- p_rail1 / p_rail0  output  2W each  product, dual-rail, registered.
- busy  output  1  high while a multiply is in progress or a result is held.
- err  output  1  sticky illegal-code flag; see Configuration.

## Operation
- All input rails and ki pass through 2-flop synchronisers. All decisions use the synchronised copies.
- Completeness of an operand set means every one of the 2W pairs is DATA. NULL means every pair is 00.
- FSM states are WAIT_DATA, MUL, WAIT_KI, HOLD and WAIT_NULL.
- WAIT_DATA: ko=1, outputs NULL, busy=0.
  - On the first edge where the synchronised inputs are complete, capture A and B (rail1 values).
  - On that edge, set ko←0 and busy←1, clear the accumulator, and go to MUL.
  - Partial operand sets (some pairs still 00) are waited on with no capture.
- MUL: exactly W cycles, one per multiplier bit, LSB first.
  - If B[i]=1, add A<<i to the 2W-bit accumulator. The accumulator is wide enough that overflow is impossible.
  - After the Wth iteration, go to WAIT_KI.
- WAIT_KI: when synced ki=1, register the product: p_rail1=P, p_rail0=~P. Go to HOLD.
- HOLD: product held stable. When synced ki=0 and synced inputs are NULL, drive the outputs to all-00 and go to WAIT_NULL.
- WAIT_NULL: one cycle, then ko←1, busy←0, and go to WAIT_DATA.
- Upstream may return to NULL at any time after ko falls. The block does not look at the inputs again until HOLD.
- ki is ignored outside WAIT_KI and HOLD.
- p_rail1 and p_rail0 are never simultaneously 1 on any bit. The transition NULL→DATA→NULL on the outputs is monotonic, with no intermediate mixed values.

## Timing
- Reset (async assert) gives: state WAIT_DATA, ko=1, p_rail1=p_rail0=0, busy=0, err=0, accumulator=0.
- Reset deassertion is synchronised internally. The first capture can happen no earlier than the 2nd edge after deassertion.
- Input change to internal visibility is 2 edges (synchroniser latency).
- Capture edge C: ko falls at C.
- MUL iterations occupy edges C+1…C+W.
- If synced ki is already 1, the product is valid at edge C+W+1. Otherwise it is valid 1 edge after synced ki rises.
- Return to NULL: outputs go to NULL 1 edge after both conditions hold in HOLD. ko rises 1 edge after that.
- Reset asserted mid-MUL or mid-HOLD: outputs go to NULL and ko goes to 1 immediately (async). The partial result is discarded and no stale product ever appears.
- Simultaneous ki fall and input NULL in the same cycle is handled as normal HOLD exit.

## Configuration
- NCL_MULT_ILLEGAL_CHK_EN defined:
  - Any synced pair equal to 11 in WAIT_DATA sets err=1.
  - err is sticky until reset.
  - The set containing the 11 pair is not treated as complete, so no capture occurs.
  - The block waits for all-NULL and then clean DATA.
- NCL_MULT_ILLEGAL_CHK_EN undefined:
  - A pair equal to 11 counts as DATA with value 1.
  - err is tied to 0.

## Test plan
- W=3, A=2, B=7, ki=1: expect p_rail1=001110 and p_rail0=110001 at C+4. Then ki=0 and inputs NULL: expect outputs all 0 and ko=1 within 2 edges.
- W=3, A=7, B=7, and A=0, B=5: expect products 110001 (49) and 000000, the latter with all p_rail0=1.
- W=8, A=255, B=255: expect product 65025 (0xFE01) at C+9 and busy high from C through HOLD exit.
- Partial arrival: A complete, B bit2 held NULL for 10 cycles: expect ko stays 1 and no capture. Then release B: expect capture 2 edges later.
- With NCL_MULT_ILLEGAL_CHK_EN, a0 rails=11: expect err=1 and ko stays 1. Then NULL followed by valid 3×3: expect product 9 with err still 1.
- rst_n pulsed low during MUL cycle 2, and separately with ki held 0 in WAIT_KI: expect immediate NULL outputs and ko=1, and the product withheld until ki=1.
